// File: rtl/four_phase_sequencer.sv
// Four-phase clock sequencer: drives one-hot phase pulses p0..p3 with a
// programmable pulse width and inter-phase gap, in burst or free-run mode.
module four_phase_sequencer #(
    parameter int unsigned WIDTH_W = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               start,
    input  logic               stop,
    input  logic               mode_burst,
    input  logic [CNT_W-1:0]   burst_len,
    input  logic [WIDTH_W-1:0] ph_width,
    input  logic [WIDTH_W-1:0] gap_len,
    output logic               p0,
    output logic               p1,
    output logic               p2,
    output logic               p3,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   cycle_cnt
);

    localparam logic [WIDTH_W-1:0] W_ONE = WIDTH_W'(1);
    localparam logic [CNT_W-1:0]   C_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        PHASE,
        GAP
    } state_t;

    state_t             state;
    logic [1:0]         idx;
    logic [WIDTH_W-1:0] cnt;
    logic [WIDTH_W-1:0] width_sh;
    logic [WIDTH_W-1:0] gap_sh;
    logic [CNT_W-1:0]   burst_sh;
    logic               mode_sh;
    logic               stop_lat;
    logic [3:0]         phase_q;

    logic [WIDTH_W-1:0] width_in;
    logic [CNT_W-1:0]   burst_in;
    logic [CNT_W-1:0]   cnt_next;
    logic               cycle_end;
    logic               finish;

    function automatic logic [3:0] onehot(input logic [1:0] k);
        logic [3:0] v;
        v = '0;
        case (k)
            2'd0:    v = 4'b0001;
            2'd1:    v = 4'b0010;
            2'd2:    v = 4'b0100;
            default: v = 4'b1000;
        endcase
        return v;
    endfunction

    // Effective config values and cycle-end / termination decode
    always_comb begin
        width_in  = (ph_width == '0) ? W_ONE : ph_width;
        burst_in  = (burst_len == '0) ? C_ONE : burst_len;
        cnt_next  = cycle_cnt + C_ONE;
        cycle_end = (state != IDLE) && (cnt == '0) && (idx == 2'd3) &&
                    ((state == GAP) || (gap_sh == '0));
        // A stop arriving in the cycle-end cycle itself still terminates here
        finish    = (mode_sh && (cnt_next == burst_sh)) || stop_lat || stop;
    end

    // Sequencer FSM with registered phase, busy, done and cycle count outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            width_sh  <= W_ONE;
            gap_sh    <= '0;
            burst_sh  <= C_ONE;
            mode_sh   <= 1'b0;
            stop_lat  <= 1'b0;
            phase_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        width_sh  <= width_in;
                        gap_sh    <= gap_len;
                        burst_sh  <= burst_in;
                        mode_sh   <= mode_burst;
                        stop_lat  <= 1'b0;
                        state     <= PHASE;
                        idx       <= 2'd0;
                        cnt       <= width_in - W_ONE;
                        phase_q   <= 4'b0001;
                        busy      <= 1'b1;
                        cycle_cnt <= '0;
                    end
                end
                PHASE, GAP: begin
                    if (stop) begin
                        stop_lat <= 1'b1;
                    end
                    if (cycle_end) begin
                        cycle_cnt <= cnt_next;
                        if (finish) begin
                            state    <= IDLE;
                            idx      <= 2'd0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            phase_q  <= '0;
                            stop_lat <= 1'b0;
                        end else begin
                            state   <= PHASE;
                            idx     <= 2'd0;
                            cnt     <= width_sh - W_ONE;
                            phase_q <= 4'b0001;
                        end
                    end else if (cnt != '0) begin
                        cnt <= cnt - W_ONE;
                    end else if ((state == PHASE) && (gap_sh != '0)) begin
                        state   <= GAP;
                        cnt     <= gap_sh - W_ONE;
                        phase_q <= '0;
                    end else begin
                        state   <= PHASE;
                        idx     <= idx + 2'd1;
                        cnt     <= width_sh - W_ONE;
                        phase_q <= onehot(idx + 2'd1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    phase_q <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign p0 = phase_q[0];
    assign p1 = phase_q[1];
    assign p2 = phase_q[2];
    assign p3 = phase_q[3];

endmodule

// File: doc/four_phase_sequencer.md
Name: four_phase_sequencer

Overview:
Programmable controller that sequences the four-phase clock outputs p0..p3 from the single system clock CLK. Each phase pulse has a configurable width, with a configurable all-low gap between phases. Supports free-running and burst operation, plus a graceful stop that always finishes the current full 4-phase cycle. Sits between the control/config logic and the phase-clocked datapath that consumes p0..p3.

Parameters:
WIDTH_W, 8, bit width of ph_width and gap_len
CNT_W, 16, bit width of burst_len and cycle_cnt

Ports:
CLK  input  1  system clock; all logic on its rising edge
RST_N  input  1  asynchronous, active-low reset
start  input  1  start request; honoured only while idle
stop  input  1  stop request; honoured only while busy
mode_burst  input  1  1 = run burst_len cycles, 0 = free-run until stop
burst_len  input  CNT_W  number of full cycles in burst mode (0 treated as 1)
ph_width  input  WIDTH_W  CLK cycles each phase is high (0 treated as 1)
gap_len  input  WIDTH_W  all-low CLK cycles after each phase (0 = no gap)
p0, p1, p2, p3  output  1  phase outputs, at most one high at any time
busy  output  1  sequence in progress
done  output  1  one-cycle pulse when a sequence ends
cycle_cnt  output  CNT_W  full cycles completed since the last accepted start

Behaviour:
- Reset (RST_N low, asynchronous): p0..p3=0, busy=0, done=0, cycle_cnt=0, stop latch cleared, FSM=IDLE.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states:
  - IDLE
  - PHASE(k), k=0..3
  - GAP(k)
- Configuration: mode_burst, burst_len, ph_width and gap_len are sampled into shadow registers on an accepted start. Input changes during a run have no effect.
- IDLE + start:
  - On the next edge: busy=1, cycle_cnt=0, FSM=PHASE(0), p0=1.
  - stop in the same cycle is ignored.
- PHASE(k): pk high for exactly ph_width_eff cycles, then:
  - GAP(k) if gap_len>0;
  - otherwise PHASE((k+1) mod 4) directly, back-to-back.
- GAP(k): all phases low for exactly gap_len cycles, then PHASE((k+1) mod 4).
- Cycle end: the last cycle of GAP(3), or of PHASE(3) when gap_len=0.
  - On the following edge, cycle_cnt increments, wrapping modulo 2^CNT_W.
  - The run terminates at that edge if either:
    - mode_burst=1 and the incremented count equals burst_len_eff; or
    - the stop latch is set.
  - On termination: FSM=IDLE, busy=0, done=1 for one cycle, all phases low, stop latch cleared.
  - Otherwise the sequence continues with PHASE(0).
- stop while busy: sets the stop latch; the current cycle runs to completion. Repeated stop pulses have no extra effect. A stop arriving in the cycle-end cycle itself terminates at that cycle end.
- start while busy: ignored, with no restart.
- start in the same cycle done is high: accepted as a normal idle start (FSM is already IDLE).
- cycle_cnt holds its final value in IDLE until the next accepted start.
- Phase width counter and gap counter are WIDTH_W bits and reload at every state entry.
- Invariant: p0..p3 are never simultaneously high (one-hot or zero) in all states, including across reset.
- Reset mid-run: outputs clear immediately (asynchronous); no done pulse.

Test Plan:
1. Burst timing. Reset, then ph_width=2, gap_len=1, mode_burst=1, burst_len=2, start pulsed at cycle 0.
   -> p0 high cycles 1-2, p1 4-5, p2 7-8, p3 10-11, second cycle p0 13-14 … p3 22-23.
   -> done=1 at cycle 25 only, busy high cycles 1-24, cycle_cnt=2 from cycle 25.
2. No gap, minimum widths. ph_width=0, gap_len=0, free-run.
   -> p0,p1,p2,p3 each high one cycle, back-to-back, period 4.
   -> cycle_cnt increments every 4 cycles; exactly one phase high every busy cycle.
3. Graceful stop. ph_width=3, gap_len=2, free-run; stop pulsed while p1 is high in the first cycle.
   -> p2 and p3 still complete; done pulses the cycle after the final gap; cycle_cnt=1.
   -> stop at the exact cycle-end cycle ends the run with no extra cycle.
4. Ignored requests.
   -> stop in IDLE: nothing.
   -> start while busy (burst_len=3): no restart; done after 3 cycles; cycle_cnt=3.
   -> start coincident with done: new run begins on the next edge with cycle_cnt=0.
5. Config isolation. Change ph_width from 2 to 5 mid-run -> widths stay 2 until the next start.
6. Async reset. Assert RST_N low mid-PHASE(2).
   -> p0..p3, busy and cycle_cnt are 0 before the next CLK edge; no done pulse.
   -> After release, a start behaves as in scenario 1.
